// File: rtl/ttl_serial_parity_rx_if.sv
// ttl_serial_parity_rx_if
// Bundles the serial-link side of the parity receiver.
//   en    : bit strobe, sin is sampled only on a clk edge with en=1
//   sin   : serial line, idles high
//   q     : last received data word
//   valid : one-clk pulse when a frame completes
//   perr  : parity error of the last completed frame
//   ferr  : framing (stop bit) error of the last completed frame
//   busy  : high while a frame is in progress
// master = line driver / observer (testbench, serializer side)
// slave  = receiver
interface ttl_serial_parity_rx_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             perr;
  logic             ferr;
  logic             busy;

  modport master (
    output en, sin,
    input  q, valid, perr, ferr, busy
  );

  modport slave (
    input  en, sin,
    output q, valid, perr, ferr, busy
  );
endinterface

// File: rtl/ttl_serial_parity_rx.sv
// ttl_serial_parity_rx
// Receiver for the XOR-parity serial link: start bit (0), WIDTH data bits
// LSB first, one parity bit, one stop bit (1). Assembles the word, checks
// parity against ODD and flags a low stop bit as a framing error.
// Ports:
//   clk : single clock, all state changes on its rising edge
//   rst : synchronous active-high reset, priority over everything
//   bus : ttl_serial_parity_rx_if.slave (en, sin in; q, valid, perr,
//         ferr, busy out)
// Clock-to-output delays (tCO_*) belong to the board-level timing view;
// this model drives its outputs with zero delay.
module ttl_serial_parity_rx #(
  parameter int WIDTH   = 8,
  parameter int ODD     = 0,
  parameter int tCO_min = 0,
  parameter int tCO_typ = 0,
  parameter int tCO_max = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  ttl_serial_parity_rx_if.slave       bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic              ODD_BIT  = (ODD != 0);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("ttl_serial_parity_rx: WIDTH must be in 1..16");
  end
  if (tCO_min > tCO_typ || tCO_typ > tCO_max) begin : g_bad_tco
    $error("ttl_serial_parity_rx: tCO must satisfy min <= typ <= max");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAITHI
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             pass;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] q_p0;
  logic             vld_p0;
  logic             perr_p0;
  logic             ferr_p0;

  // Bits arrive LSB first: each new bit enters at the top and the word
  // slides down, so after WIDTH bits the first one sits in bit 0.
  always_comb begin
    shreg_nxt            = shreg >> 1;
    shreg_nxt[WIDTH-1]   = bus.sin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.en) begin
      unique case (state)
        S_IDLE:   if (!bus.sin) state_nxt = S_DATA;
        S_DATA:   if (cnt == CNT_LAST) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        // A low stop bit parks in WAITHI so the still-low line is not
        // mistaken for the next start bit.
        S_STOP:   state_nxt = bus.sin ? S_IDLE : S_WAITHI;
        S_WAITHI: if (bus.sin) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame datapath and result registers; all hold while en=0 except the
  // valid pulse, which is cleared on every non-completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= 1'b0;
      q_p0    <= '0;
      vld_p0  <= 1'b0;
      perr_p0 <= 1'b0;
      ferr_p0 <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (bus.en) begin
        unique case (state)
          S_IDLE: begin
            if (!bus.sin) begin
              cnt <= '0;
              acc <= 1'b0;
            end
          end
          S_DATA: begin
            shreg <= shreg_nxt;
            acc   <= acc ^ bus.sin;
            cnt   <= cnt + 1'b1;
          end
          S_PARITY: begin
            pass <= ((acc ^ bus.sin) == ODD_BIT);
          end
          S_STOP: begin
            q_p0    <= shreg;
            vld_p0  <= 1'b1;
            perr_p0 <= !pass;
            ferr_p0 <= !bus.sin;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.q     = q_p0;
  assign bus.valid = vld_p0;
  assign bus.perr  = perr_p0;
  assign bus.ferr  = ferr_p0;
  assign bus.busy  = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);

endmodule
